uart_tx_sched: RTL and testbench

Round-robin scheduler that shares the single UART transmit datapath among four byte requesters. It sits between the on-chip byte sources (status reporter, loopback echo, boot-log, debug) and the UART transmitter. The scheduler drives the transmitter's one-cycle start strobe and byte bus, tracks the frame through the transmitter's busy flag, enforces an inter-frame guard gap, and reports accept/complete per requester.

---
 rtl/uart_tx_sched.sv | 122 ++++++++++++
 tb/tb_uart_tx_sched.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART transmitter among four byte requesters.
// It issues the start strobe and byte, tracks the frame, then holds a guard gap.
//
//   state      | meaning
//   IDLE       | waiting for a pending req while the transmitter is idle
//   SEND       | one-cycle start strobe and ack to the winner
//   WAIT_START | waiting for the transmitter to raise tx_busy
//   WAIT_END   | waiting for tx_busy to fall, then one cycle of done
//   GAP        | inter-frame guard, req ignored
module uart_tx_sched #(
    parameter int unsigned GAP_CYC = 16,
    parameter int unsigned GAP_W   = 8
) (
    input  logic        sclk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [31:0] req_data,
    input  logic        tx_busy,
    output logic        po_flag,
    output logic [7:0]  po_data,
    output logic [3:0]  ack,
    output logic [3:0]  done,
    output logic [1:0]  grant_id,
    output logic        busy
);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_START,
        WAIT_END,
        GAP
    } state_t;

    localparam int unsigned      GAP_LOAD_I = (GAP_CYC == 0) ? 0 : GAP_CYC - 1;
    localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_LOAD_I[GAP_W-1:0];
    localparam logic [GAP_W-1:0] GAP_ONE    = 1;

    state_t           state, state_nxt;
    logic [GAP_W-1:0] gap_cnt, gap_nxt;
    logic             end_seen, end_nxt;
    logic [1:0]       grant_nxt;
    logic [7:0]       data_nxt;
    logic [1:0]       win, idx;
    logic             found;

    // Search starts one past the last grant and wraps.
    always_comb begin
        win   = grant_id;
        idx   = grant_id;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = grant_id + 2'(i);
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gap_nxt   = gap_cnt;
        end_nxt   = end_seen;
        grant_nxt = grant_id;
        data_nxt  = po_data;
        unique case (state)
            IDLE: begin
                if (found && !tx_busy) begin
                    grant_nxt = win;
                    data_nxt  = req_data[{win, 3'b000} +: 8];
                    state_nxt = SEND;
                end
            end
            SEND: state_nxt = WAIT_START;
            WAIT_START: begin
                if (tx_busy) state_nxt = WAIT_END;
            end
            WAIT_END: begin
                // First low sample arms done for one cycle; leave on the following edge.
                if (end_seen) begin
                    end_nxt = 1'b0;
                    if (GAP_CYC == 0) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = GAP;
                        gap_nxt   = GAP_LOAD;
                    end
                end else if (!tx_busy) begin
                    end_nxt = 1'b1;
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
                else               gap_nxt   = gap_cnt - GAP_ONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sclk) begin
        if (!rst_n) begin
            state    <= IDLE;
            gap_cnt  <= '0;
            end_seen <= 1'b0;
            grant_id <= 2'd3;
            po_data  <= 8'h00;
        end else begin
            state    <= state_nxt;
            gap_cnt  <= gap_nxt;
            end_seen <= end_nxt;
            grant_id <= grant_nxt;
            po_data  <= data_nxt;
        end
    end

    assign po_flag = (state == SEND);
    assign ack     = po_flag ? (4'b0001 << grant_id) : 4'b0000;
    assign done    = (state == WAIT_END && end_seen) ? (4'b0001 << grant_id) : 4'b0000;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_sched.sv
// Bench for uart_tx_sched: directed scenarios on a GAP_CYC=16 instance plus a
// GAP_CYC=0 instance, both checked every cycle against a timestamp-based model.
module tb_uart_tx_sched;

    localparam int G_A   = 16;
    localparam int G_B   = 0;
    localparam int FRAME = 5;

    logic        sclk;
    logic        rst_n;
    logic [3:0]  req_a, req_b;
    logic [31:0] data_a, data_b;
    logic        tx_auto_a, tx_auto_b, tx_force;
    logic        txb_a, txb_b;

    logic        po_flag_a, po_flag_b, busy_a, busy_b;
    logic [7:0]  po_data_a, po_data_b;
    logic [3:0]  ack_a, ack_b, done_a, done_b;
    logic [1:0]  grant_a, grant_b;

    assign txb_a = tx_auto_a | tx_force;
    assign txb_b = tx_auto_b;

    uart_tx_sched #(.GAP_CYC(G_A), .GAP_W(8)) dut_a (
        .sclk(sclk), .rst_n(rst_n), .req(req_a), .req_data(data_a), .tx_busy(txb_a),
        .po_flag(po_flag_a), .po_data(po_data_a), .ack(ack_a), .done(done_a),
        .grant_id(grant_a), .busy(busy_a)
    );

    uart_tx_sched #(.GAP_CYC(G_B), .GAP_W(8)) dut_b (
        .sclk(sclk), .rst_n(rst_n), .req(req_b), .req_data(data_b), .tx_busy(txb_b),
        .po_flag(po_flag_b), .po_data(po_data_b), .ack(ack_b), .done(done_b),
        .grant_id(grant_b), .busy(busy_b)
    );

    initial sclk = 1'b0;
    always #5 sclk = ~sclk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at cycle %0d: event never arrived", name, cyc);
    endtask

    // Model: timestamps of grant and done; eligibility resumes at done + gap + 2.
    typedef struct {
        int         stage;
        int         grant_e;
        int         done_e;
        int         ready;
        logic [1:0] last;
        logic [7:0] data;
    } mdl_t;

    mdl_t ma = '{stage: 0, grant_e: -1, done_e: -1, ready: 0, last: 2'd3, data: 8'h00};
    mdl_t mb = '{stage: 0, grant_e: -1, done_e: -1, ready: 0, last: 2'd3, data: 8'h00};

    function automatic mdl_t mdl_step(input mdl_t m, input int e, input int g, input logic rs,
                                      input logic [3:0] rq, input logic [31:0] rd, input logic tb);
        mdl_t n = m;
        int   w = -1;
        if (!rs) begin
            n.stage = 0; n.grant_e = -1; n.done_e = -1; n.ready = e + 1;
            n.last = 2'd3; n.data = 8'h00;
            return n;
        end
        case (n.stage)
            0: if (e >= n.ready && rq != 4'b0000 && !tb) begin
                for (int off = 1; off <= 4; off++)
                    if (w < 0 && rq[(n.last + off) % 4]) w = (n.last + off) % 4;
                n.last    = 2'(w);
                n.data    = rd[8*w +: 8];
                n.grant_e = e;
                n.stage   = 1;
            end
            1: if (e >= n.grant_e + 2 && tb) n.stage = 2;
            2: if (!tb) begin
                n.done_e = e;
                n.ready  = e + g + 2;
                n.stage  = 0;
            end
            default: ;
        endcase
        return n;
    endfunction

    function automatic logic [19:0] mdl_out(input mdl_t m, input int e);
        logic       po;
        logic [3:0] oh;
        oh = 4'b0001 << m.last;
        po = (m.grant_e == e);
        return {po, m.data, po ? oh : 4'b0000, (m.done_e == e) ? oh : 4'b0000, m.last,
                (m.stage != 0) || (e < m.ready - 1)};
    endfunction

    initial begin
        forever begin
            @(posedge sclk);
            cyc++;
            ma = mdl_step(ma, cyc, G_A, rst_n, req_a, data_a, txb_a);
            mb = mdl_step(mb, cyc, G_B, rst_n, req_b, data_b, txb_b);
            @(negedge sclk);
            check("dut_a_outputs", {12'h0, po_flag_a, po_data_a, ack_a, done_a, grant_a, busy_a},
                  {12'h0, mdl_out(ma, cyc)});
            check("dut_b_outputs", {12'h0, po_flag_b, po_data_b, ack_b, done_b, grant_b, busy_b},
                  {12'h0, mdl_out(mb, cyc)});
        end
    end

    // Transmitter stand-ins: busy for FRAME cycles starting the cycle after the strobe.
    initial begin
        logic pf, rs;
        int   cnt = 0;
        tx_auto_a = 1'b0;
        forever begin
            @(negedge sclk); pf = po_flag_a; rs = rst_n;
            @(posedge sclk); #1;
            if (!rs) begin tx_auto_a = 1'b0; cnt = 0; end
            else if (pf) begin tx_auto_a = 1'b1; cnt = FRAME; end
            else if (cnt > 0) begin cnt--; if (cnt == 0) tx_auto_a = 1'b0; end
        end
    end

    initial begin
        logic pf, rs;
        int   cnt = 0;
        tx_auto_b = 1'b0;
        forever begin
            @(negedge sclk); pf = po_flag_b; rs = rst_n;
            @(posedge sclk); #1;
            if (!rs) begin tx_auto_b = 1'b0; cnt = 0; end
            else if (pf) begin tx_auto_b = 1'b1; cnt = FRAME; end
            else if (cnt > 0) begin cnt--; if (cnt == 0) tx_auto_b = 1'b0; end
        end
    end

    // Zero-gap instance: done to next strobe with req[0] always pending.
    int gap0_hits = 0;
    initial begin
        int last_d = -1;
        forever begin
            @(negedge sclk);
            if (!rst_n) last_d = -1;
            else begin
                if (po_flag_b && last_d >= 0 && gap0_hits < 4) begin
                    check("gap0_done_to_po_flag", cyc - last_d, 2);
                    gap0_hits++;
                end
                if (done_b != 4'b0000) last_d = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge sclk); #1;
    endtask

    task automatic wait_pf_a(input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge sclk);
            if (po_flag_a) begin at = cyc; break; end
        end
        if (at < 0) timeout("wait_po_flag");
    endtask

    task automatic wait_done_a(input int lim, output int at, output logic [3:0] val);
        at = -1; val = 4'b0000;
        for (int i = 0; i < lim; i++) begin
            @(negedge sclk);
            if (done_a != 4'b0000) begin at = cyc; val = done_a; break; end
        end
        if (at < 0) timeout("wait_done");
    endtask

    task automatic wait_tx_a(input logic lvl, input int lim, output int at);
        at = -1;
        for (int i = 0; i < lim; i++) begin
            @(negedge sclk);
            if (txb_a == lvl) begin at = cyc; break; end
        end
        if (at < 0) timeout("wait_tx_busy");
    endtask

    initial begin
        int         t, s, d, f, n;
        logic [3:0] dv;
        int         exp_id[5] = '{0, 1, 2, 3, 0};
        int         gid[5];
        logic [7:0] gdat[5];
        logic [3:0] gack[5];

        rst_n = 1'b0; req_a = 4'b0; req_b = 4'b0; tx_force = 1'b0;
        data_a = 32'h0; data_b = 32'h0000_005A;
        repeat (3) tick();
        @(negedge sclk);
        check("reset_flags", {po_flag_a, ack_a, done_a, busy_a}, 10'h0);
        check("reset_grant_id", grant_a, 2'd3);
        check("reset_po_data", po_data_a, 8'h00);
        tick(); rst_n = 1'b1; req_b = 4'b0001;

        // Single requester
        tick(); req_a = 4'b0010; data_a = 32'h0000_A500; s = cyc;
        wait_pf_a(10, t);
        check("single_latency", t - s, 1);
        check("single_po_flag", po_flag_a, 1'b1);
        check("single_ack", ack_a, 4'b0010);
        check("single_po_data", po_data_a, 8'hA5);
        check("single_grant_id", grant_a, 2'd1);
        tick(); req_a = 4'b0000;
        wait_tx_a(1'b1, 20, f);
        wait_tx_a(1'b0, 20, f);
        wait_done_a(20, d, dv);
        check("single_done", dv, 4'b0010);
        check("single_done_delay", d - f, 1);

        // Round robin with all requests held
        tick(); rst_n = 1'b0;
        tick(); tick(); rst_n = 1'b1;
        req_a = 4'b1111; data_a = 32'h1312_1110;
        for (int k = 0; k < 5; k++) begin
            wait_pf_a(60, t);
            gid[k] = grant_a; gdat[k] = po_data_a; gack[k] = ack_a;
        end
        tick(); req_a = 4'b0000;
        for (int k = 0; k < 5; k++) begin
            check("rr_grant_order", gid[k], exp_id[k]);
            check("rr_po_data", gdat[k], 8'h10 + 8'(exp_id[k]));
            check("rr_ack", gack[k], 4'b0001 << exp_id[k]);
        end

        // Wrap: last grant 2, then 3 and 0 pending
        req_a = 4'b0100;
        wait_pf_a(60, t);
        check("wrap_setup_grant", grant_a, 2'd2);
        tick(); req_a = 4'b1001;
        wait_pf_a(60, t);
        check("wrap_first", grant_a, 2'd3);
        tick(); req_a = 4'b0001;
        wait_pf_a(60, t);
        check("wrap_second", grant_a, 2'd0);
        tick(); req_a = 4'b0000;

        // Guard gap, back-to-back requests
        req_a = 4'b0011;
        wait_pf_a(60, t);
        dv = ack_a;
        tick(); req_a = req_a & ~dv;
        wait_done_a(30, d, dv);
        wait_pf_a(40, t);
        check("gap16_done_to_po_flag", t - d, G_A + 2);
        tick(); req_a = 4'b0000;

        // One-cycle req pulse during the gap is dropped
        wait_done_a(30, d, dv);
        tick(); tick(); tick(); req_a = 4'b0001;
        tick(); req_a = 4'b0000;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge sclk);
            if (po_flag_a || ack_a != 4'b0000) n++;
        end
        check("withdraw_no_grant", n, 0);

        // Stale tx_busy in IDLE defers the grant
        tick(); rst_n = 1'b0; tx_force = 1'b1;
        tick(); rst_n = 1'b1; req_a = 4'b0100;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge sclk);
            if (po_flag_a) n++;
        end
        check("stale_busy_no_grant", n, 0);
        tick(); tx_force = 1'b0; s = cyc;
        wait_pf_a(10, t);
        check("stale_busy_release", t - s, 1);
        check("stale_busy_grant", grant_a, 2'd2);
        tick(); req_a = 4'b0000;

        // Reset while waiting for the frame end
        wait_tx_a(1'b1, 20, f);
        tick(); tick(); rst_n = 1'b0;
        tick(); rst_n = 1'b1;
        @(negedge sclk);
        check("midreset_flags", {po_flag_a, ack_a, done_a, busy_a}, 10'h0);
        check("midreset_grant_id", grant_a, 2'd3);
        check("midreset_po_data", po_data_a, 8'h00);
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge sclk);
            if (done_a != 4'b0000) n++;
        end
        check("midreset_no_done", n, 0);

        check("gap0_samples_seen", gap0_hits >= 3, 1'b1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog at cycle %0d: bench did not finish", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
